// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand deserializer.
//
// Frame layout, MSB first on the wire: A[7:0], B[7:0], Cantidad[1:0].
// Field offsets below are bit positions inside the assembled 18-bit frame word.
// When ALU_DESER_PARITY_EN is defined, an even-parity bit follows the payload.

package alu_pkg;

    localparam int unsigned FRAME_BITS = 18;
    localparam int unsigned A_W        = 8;
    localparam int unsigned B_W        = 8;
    localparam int unsigned CANT_W     = 2;

    // Field offsets within the frame word (LSB positions).
    localparam int unsigned CANT_LSB   = 0;
    localparam int unsigned B_LSB      = CANT_LSB + CANT_W;
    localparam int unsigned A_LSB      = B_LSB + B_W;

    // Bit counter width; must hold FRAME_BITS (the parity-bit count value).
    localparam int unsigned CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } deser_state_t;

    // True when payload plus parity bit carry an even number of ones.
    function automatic logic even_parity_ok(input logic [FRAME_BITS-1:0] word,
                                            input logic                  par_bit);
        return ~(^{word, par_bit});
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in parallel-out shift register, MSB first: each enabled cycle shifts
// the register left by one and inserts din at bit 0.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   clr   synchronous clear (takes priority over en)
//   en    shift enable
//   din   serial input bit
//   q     parallel contents

module sipo_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (clr) begin
            sr_d = '0;
        end else if (en) begin
            sr_d = {sr_q[WIDTH-2:0], din};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q;

endmodule

// File: rtl/alu_operand_deserializer.sv
// Serial operand receiver for the ALU front end. Collects an MSB-first frame
// (A, B, Cantidad) from one pin and presents the fields as parallel operands
// with a valid/ack handshake.
//
// Build option: define ALU_DESER_PARITY_EN to append an even-parity bit to
// each frame; a parity mismatch is reported on frame_err and the frame dropped.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   sdata_in   serial data, sampled when sframe=1
//   sframe     frame enable, high for every bit of a frame
//   op_ack     consumer accepts current operands
//   A, B       8-bit operands
//   Cantidad   2-bit shift amount
//   op_valid   operands valid, held until acknowledged
//   busy       frame in progress (registered, bit counter != 0)
//   frame_err  one-cycle pulse on aborted or bad-parity frame
//   overrun    sticky: a completed frame overwrote unacknowledged operands

module alu_operand_deserializer
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sdata_in,
    input  logic       sframe,
    input  logic       op_ack,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic [1:0] Cantidad,
    output logic       op_valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    deser_state_t            state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [A_W-1:0]          a_q, a_d;
    logic [B_W-1:0]          b_q, b_d;
    logic [CANT_W-1:0]       cant_q, cant_d;
    logic                    op_valid_q, op_valid_d;
    logic                    busy_q, busy_d;
    logic                    frame_err_q, frame_err_d;
    logic                    overrun_q, overrun_d;

    logic                    sr_en;
    logic                    sr_clr;
    logic [FRAME_BITS-1:0]   sr_q;
    logic                    load;
    logic [FRAME_BITS-1:0]   load_word;

    sipo_shift_reg #(
        .WIDTH (FRAME_BITS)
    ) u_sipo (
        .clk  (clk),
        .rst  (rst),
        .clr  (sr_clr),
        .en   (sr_en),
        .din  (sdata_in),
        .q    (sr_q)
    );

    // Frame FSM and bit counter.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sr_en       = 1'b0;
        sr_clr      = 1'b0;
        load        = 1'b0;
        load_word   = sr_q;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (sframe) begin
                    sr_en   = 1'b1;
                    count_d = CNT_W'(1);
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (!sframe) begin
                    frame_err_d = 1'b1;
                    sr_clr      = 1'b1;
                    count_d     = '0;
                    state_d     = IDLE;
                end else if (count_q == CNT_W'(FRAME_BITS - 1)) begin
`ifdef ALU_DESER_PARITY_EN
                    sr_en   = 1'b1;
                    count_d = CNT_W'(FRAME_BITS);
                    state_d = PARITY;
`else
                    // Final bit goes straight to the outputs, bypassing the register.
                    load      = 1'b1;
                    load_word = {sr_q[FRAME_BITS-2:0], sdata_in};
                    sr_clr    = 1'b1;
                    count_d   = '0;
                    state_d   = IDLE;
`endif
                end else begin
                    sr_en   = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end
            end

            PARITY: begin
`ifdef ALU_DESER_PARITY_EN
                if (!sframe) begin
                    frame_err_d = 1'b1;
                end else if (even_parity_ok(sr_q, sdata_in)) begin
                    load = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
`endif
                sr_clr  = 1'b1;
                count_d = '0;
                state_d = IDLE;
            end

            default: begin
                sr_clr  = 1'b1;
                count_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Output registers and handshake.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        cant_d = cant_q;
        if (load) begin
            a_d    = load_word[A_LSB +: A_W];
            b_d    = load_word[B_LSB +: B_W];
            cant_d = load_word[CANT_LSB +: CANT_W];
        end

        // An ack in the completion cycle retires the old set, so the new one is no overrun.
        op_valid_d = (op_valid_q & ~op_ack) | load;
        overrun_d  = overrun_q | (load & op_valid_q & ~op_ack);
        busy_d     = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cant_q      <= '0;
            op_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cant_q      <= cant_d;
            op_valid_q  <= op_valid_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign Cantidad  = cant_q;
    assign op_valid  = op_valid_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_alu_operand_deserializer.sv
// Self-checking bench for alu_operand_deserializer. Expected operand sets are
// queued as frames are driven and popped when the DUT presents them.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the
// rising edge.

module tb_alu_operand_deserializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       sdata_in;
    logic       sframe;
    logic       op_ack;
    logic [7:0] A;
    logic [7:0] B;
    logic [1:0] Cantidad;
    logic       op_valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] c;
    } ops_t;

    ops_t        sb[$];
    ops_t        last_ops;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    alu_operand_deserializer dut (
        .clk       (clk),
        .rst       (rst),
        .sdata_in  (sdata_in),
        .sframe    (sframe),
        .op_ack    (op_ack),
        .A         (A),
        .B         (B),
        .Cantidad  (Cantidad),
        .op_valid  (op_valid),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        sframe   = 1'b1;
        sdata_in = b;
    endtask

    task automatic go_idle();
        @(negedge clk);
        sframe   = 1'b0;
        sdata_in = 1'b0;
    endtask

    // Drives one frame, leaving sframe high after the last bit. bad_par flips
    // the parity bit (parity builds only); ack_last raises op_ack with the final bit.
    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [1:0] c,
                              input bit bad_par, input bit ack_last);
        logic [17:0] w;
        w = {a, b, c};
        for (int i = 17; i >= 0; i--) begin
            send_bit(w[i]);
`ifndef ALU_DESER_PARITY_EN
            if (i == 0 && ack_last) op_ack = 1'b1;
`endif
        end
`ifdef ALU_DESER_PARITY_EN
        send_bit((^w) ^ bad_par);
        if (ack_last) op_ack = 1'b1;
        if (!bad_par) sb.push_back({a, b, c});
`else
        sb.push_back({a, b, c});
`endif
    endtask

    // Waits for the edge that samples the final bit, then compares against the queue.
    task automatic expect_load(input string tag);
        ops_t e;
        tick_sample();
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_sb: got empty queue expected an entry", tag);
            return;
        end
        e = sb.pop_front();
        check_eq({tag, "_A"}, A, e.a);
        check_eq({tag, "_B"}, B, e.b);
        check_eq({tag, "_Cant"}, Cantidad, e.c);
        check_eq({tag, "_valid"}, op_valid, 1);
        last_ops = e;
    endtask

    initial begin
        logic [17:0] w;
        rst      = 1'b1;
        sframe   = 1'b0;
        sdata_in = 1'b0;
        op_ack   = 1'b0;
        last_ops = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_A", A, 0);
        check_eq("rst_B", B, 0);
        check_eq("rst_Cant", Cantidad, 0);
        check_eq("rst_valid", op_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ferr", frame_err, 0);
        check_eq("rst_ovr", overrun, 0);
        @(negedge clk);
        rst = 1'b0;

        // Abort after 9 bits.
        w = {8'h5A, 8'hC3, 2'b01};
        for (int i = 17; i >= 9; i--) send_bit(w[i]);
        tick_sample();
        check_eq("abort_busy_mid", busy, 1);
        go_idle();
        tick_sample();
        check_eq("abort_ferr", frame_err, 1);
        check_eq("abort_busy", busy, 0);
        tick_sample();
        check_eq("abort_ferr_pulse", frame_err, 0);
        check_eq("abort_A", A, 0);
        check_eq("abort_valid", op_valid, 0);

        // Basic frame with delayed ack: op_valid high exactly two cycles.
        send_frame(8'hA5, 8'h3C, 2'b10, 1'b0, 1'b0);
        expect_load("f1");
        check_eq("f1_busy", busy, 0);
        go_idle();
        tick_sample();
        check_eq("f1_valid_c2", op_valid, 1);
        @(negedge clk);
        op_ack = 1'b1;
        tick_sample();
        check_eq("f1_valid_clr", op_valid, 0);
        check_eq("f1_busy_after", busy, 0);
        @(negedge clk);
        op_ack = 1'b0;

        // Back-to-back frames without ack.
        send_frame(8'h01, 8'h02, 2'b01, 1'b0, 1'b0);
        expect_load("b2b1");
        check_eq("b2b1_ovr", overrun, 0);
        send_frame(8'hFF, 8'h80, 2'b11, 1'b0, 1'b0);
        expect_load("b2b2");
        check_eq("b2b2_ovr", overrun, 1);
        go_idle();
        repeat (3) tick_sample();
        check_eq("b2b_ovr_sticky", overrun, 1);

        // Reset after 12 bits.
        w = {8'h99, 8'h66, 2'b11};
        for (int i = 17; i >= 6; i--) send_bit(w[i]);
        @(negedge clk);
        rst    = 1'b1;
        sframe = 1'b0;
        tick_sample();
        check_eq("mrst_A", A, 0);
        check_eq("mrst_B", B, 0);
        check_eq("mrst_Cant", Cantidad, 0);
        check_eq("mrst_valid", op_valid, 0);
        check_eq("mrst_ovr", overrun, 0);
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_ferr", frame_err, 0);
        rst = 1'b0;
        send_frame(8'hC3, 8'h5E, 2'b01, 1'b0, 1'b0);
        expect_load("post_rst");
        check_eq("post_rst_ferr", frame_err, 0);

        // Completion coinciding with ack: new data, valid stays, no overrun.
        send_frame(8'h77, 8'h88, 2'b00, 1'b0, 1'b1);
        expect_load("ack_same");
        check_eq("ack_same_ovr", overrun, 0);
        @(negedge clk);
        op_ack = 1'b0;
        sframe = 1'b0;

`ifdef ALU_DESER_PARITY_EN
        op_ack = 1'b1;
        @(negedge clk);
        op_ack = 1'b0;
        send_frame(8'hA5, 8'h3C, 2'b10, 1'b0, 1'b0);
        expect_load("par_good");
        @(negedge clk);
        sframe = 1'b0;
        op_ack = 1'b1;
        @(negedge clk);
        op_ack = 1'b0;
        send_frame(8'hA5, 8'h3C, 2'b10, 1'b1, 1'b0);
        tick_sample();
        check_eq("par_bad_ferr", frame_err, 1);
        check_eq("par_bad_valid", op_valid, 0);
        check_eq("par_bad_A", A, last_ops.a);
`endif

        go_idle();
        tick_sample();
        check_eq("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_deserializer.md
# alu_operand_deserializer

Serial operand receiver at the front of the ALU. It collects an 18-bit MSB-first serial frame from a single input pin, then presents the fields as parallel operands A, B and Cantidad to the shifter and ALU datapath with a valid/ack handshake. It is the producer end of the shifter operand interface and lets the design load operands through one pin instead of 18.

## Interface
- FRAME_BITS, 18: payload bits per frame (A 8 + B 8 + Cantidad 2); fixed, not overridable.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- sdata_in  in  1  serial data bit, sampled when sframe=1
- sframe  in  1  frame enable; high for every bit of a frame
- op_ack  in  1  consumer accepts current operands
- A  out  8  operand A
- B  out  8  operand B
- Cantidad  out  2  shift amount
- op_valid  out  1  operands valid, held until acknowledged
- busy  out  1  frame in progress (bit counter ≠ 0)
- frame_err  out  1  one-cycle pulse on an aborted or bad frame
- overrun  out  1  sticky: a completed frame overwrote unacknowledged operands

## Operation
- Bit order on the wire: A[7]..A[0], B[7]..B[0], Cantidad[1], Cantidad[0].
- States: IDLE (count=0), SHIFT (count 1..17), plus PARITY when PARITY_EN is defined.
- IDLE: sframe=1 captures bit 0, count→1, go to SHIFT. sframe=0: stay.
- SHIFT: sframe=1 shifts the bit in and increments count. On the final payload bit (count=17), the output registers load the complete 18-bit word, op_valid←1, count→0, go to IDLE.
- sframe=0 in SHIFT: abort, frame_err pulses, count→0, shift register cleared, outputs/op_valid unchanged, go to IDLE.
- Back-to-back frames: sframe held high continuously. The bit after completion starts the next frame with no gap cycle.
- Handshake: op_valid clears on the edge where op_valid=1 and op_ack=1. op_ack with op_valid=0 is ignored.
- Completion while op_valid=1 and op_ack=0: outputs overwritten, op_valid stays 1, overrun←1 (sticky until rst).
- Completion in the same cycle as op_ack: new data loaded, op_valid stays 1, no overrun.
- Reset values: A=0, B=0, Cantidad=0, op_valid=0, busy=0, frame_err=0, overrun=0, count=0, shift register=0, state IDLE.
- Reset mid-frame discards the partial frame; no frame_err is raised.

## Timing
- Each bit is sampled on the rising clk edge with sframe=1.
- A/B/Cantidad and op_valid are valid in the cycle after the edge that samples the final bit.
- Minimum frame length is 18 cycles (19 with PARITY_EN). Maximum sustained rate is one operand set per frame time.
- frame_err is exactly one cycle wide, asserted in the cycle after the abort edge.
- busy is registered: high from the cycle after the first bit until the cycle after completion or abort.
- Outputs update atomically; partial frames are never visible on A/B/Cantidad.

## Configuration
- ALU_DESER_PARITY_EN defined: one extra bit follows Cantidad[0], making the frame even parity across all 19 bits.
  - Correct parity: the load proceeds as above.
  - Mismatch: frame_err pulses and outputs/op_valid are unchanged.
  - sframe=0 during the parity bit counts as an abort.
- Not defined: 18-bit frames, no parity check.

## Structure
- Shared package alu_pkg holds:
  - FRAME_BITS, A_W=8, B_W=8, CANT_W=2
  - field bit offsets within the frame word
  - deser_state_t enum {IDLE, SHIFT, PARITY}
- One sub-module: sipo_shift_reg (parameterized width, shift enable, synchronous clear, MSB-first). The FSM, counter, handshake and parity logic stay in the top.

## Test plan
- Frame A=0xA5, B=0x3C, Cantidad=2'b10 (bits 10100101 00111100 10), then op_ack one cycle later -> op_valid high for exactly 2 cycles; outputs 0xA5/0x3C/2; busy low afterward.
- sframe dropped after 9 bits -> frame_err one-cycle pulse; outputs remain reset values; op_valid=0; next full frame loads correctly.
- Two back-to-back frames (0x01/0x02/1, then 0xFF/0x80/3), no ack -> second frame overwrites the first; overrun=1 until rst.
- Completion coinciding with op_ack -> new data loaded, op_valid stays 1, overrun stays 0.
- rst asserted at bit 12 of a frame -> all outputs 0, state IDLE; a following frame starting the next cycle decodes correctly.
- With ALU_DESER_PARITY_EN: frame 0xA5/0x3C/2 with parity bit 1 -> loaded; same frame with parity bit 0 -> frame_err pulse, no load.
